lsu_mem_access: RTL and testbench
=================================

// Module: lsu_mem_access
// PURPOSE
//   Executes the memory access selected by the decoder's one-hot load/store strobes (lb..lwu, sb..sd).
//   Sits between execute and writeback. Takes one request per handshake and drives a single-beat req/ack
//   data-memory bus with 8-byte-aligned address and byte-write mask. For loads, extracts the addressed
//   lane and sign/zero extends it. Responds with rdata or error to writeback.
// PARAMETERS
//   AW   64   address width (bits); data path is fixed at 64 bits / 8 byte lanes
// PORTS
//   clk        in   1    clock, rising edge
//   rst_n      in   1    asynchronous active-low reset
//   req_valid  in   1    request present (one strobe below asserted)
//   req_ready  out  1    LSU accepts request this cycle
//   lb,lh,lw,ld,lbu,lhu,lwu  in 1 each  load strobes from decoder
//   sb,sh,sw,sd              in 1 each  store strobes from decoder
//   addr       in   AW   effective byte address (rs1+imm)
//   wdata      in   64   store data (rs2), low bytes significant
//   mem_req    out  1    memory request, held until mem_ack
//   mem_we     out  1    1=write, 0=read
//   mem_addr   out  AW   {addr[AW-1:3],3'b0}
//   mem_wdata  out  64   store data shifted to byte lane
//   mem_wmask  out  8    byte enables (read: mask of bytes used)
//   mem_ack    in   1    memory completes the access (same cycle rdata valid)
//   mem_rdata  in   64   read data, 8-byte aligned word
//   rsp_valid  out  1    response present
//   rsp_ready  in   1    writeback accepts response
//   rsp_rdata  out  64   extended load result (0 for stores)
//   rsp_err    out  1    misaligned or illegal request; no memory access was made
// BEHAVIOUR
//   FSM: IDLE -> REQ -> RSP -> IDLE. req_ready=1 only in IDLE. Request is accepted when req_valid & req_ready.
//   On accept, all request fields are registered. Legal and aligned -> REQ. Otherwise -> RSP with rsp_err=1.
//   Size: b=1, h=2, w=4, d=8 bytes. Aligned if addr mod size == 0. Lane offset is o=addr[2:0].
//   Illegal: zero strobes, or more than one strobe asserted (counted across all 11). Such a request
//     gets rsp_err=1 and rsp_rdata=0.
//   REQ: mem_req=1; mem_addr, mem_we, mem_wmask and mem_wdata are stable until mem_ack.
//     mem_wmask = ((1<<size)-1) << o.
//     mem_wdata = wdata << (8*o).
//     On mem_ack -> RSP, and mem_rdata is captured that cycle. mem_req deasserts the cycle after ack.
//   Load result: lane = mem_rdata >> (8*o), truncated to size.
//     lb/lh/lw sign-extend; lbu/lhu/lwu zero-extend; ld passes through.
//   RSP: rsp_valid=1, with rsp_rdata/rsp_err stable. Leave to IDLE when rsp_ready=1.
//     Earliest next accept is the following cycle. Minimum latency accept->rsp_valid is 2 cycles with ack
//     in first REQ cycle; an error takes 1 cycle.
//   No mem_ack timeout; REQ waits indefinitely. A mem_ack outside REQ is ignored.
//   Reset (any state, async): state=IDLE. All outputs go to 0 except req_ready=1, including
//     mem_req/mem_we/mem_wmask/mem_addr/mem_wdata/rsp_*. An in-flight access is abandoned with no response.
// TESTING
//   lw addr=0x...1004, mem_rdata=0x8000_0001_8765_4321, ack in 1st REQ cycle
//     -> mem_addr=0x...1000, wmask=0xF0, rsp_rdata=0xFFFF_FFFF_8000_0001 two cycles after accept.
//   lbu addr=0x...07, mem_rdata=0xAB00_..._00 -> wmask=0x80, rsp_rdata=0x0000_0000_0000_00AB;
//     same with lb -> 0xFFFF_FFFF_FFFF_FFAB.
//   sh addr=0x...02, wdata=0x1234_5678_9ABC_DEF0 -> mem_we=1, wmask=0x0C,
//     mem_wdata[31:16]=0xDEF0, rsp_rdata=0, rsp_err=0.
//   sd addr=0x...04 (misaligned); lw+sw both set; no strobe
//     -> mem_req never asserts, rsp_valid next cycle with rsp_err=1.
//   mem_ack delayed 5 cycles and rsp_ready held low 3 cycles
//     -> mem outputs stable during wait, rsp stable during stall, req_ready=0 until RSP exits.
//   rst_n low while in REQ -> mem_req=0 immediately (async); after release req_ready=1 and no stale rsp_valid.

Source files
------------

// File: rtl/lsu_mem_access.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_access
// Description : Load/store unit memory stage. Accepts one decoded load/store
//               per handshake, issues one single-beat req/ack access with
//               an aligned address and byte mask, then returns the extended
//               load data or an error flag to writeback.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_access #(
   parameter int AW = 64
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          lb,
   input  logic          lh,
   input  logic          lw,
   input  logic          ld,
   input  logic          lbu,
   input  logic          lhu,
   input  logic          lwu,
   input  logic          sb,
   input  logic          sh,
   input  logic          sw,
   input  logic          sd,
   input  logic [AW-1:0] addr,
   input  logic [63:0]   wdata,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [63:0]   mem_wdata,
   output logic [7:0]    mem_wmask,
   input  logic          mem_ack,
   input  logic [63:0]   mem_rdata,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [63:0]   rsp_rdata,
   output logic          rsp_err
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_RSP  = 2'd2;

   logic [1:0]    r_state;
   logic [1:0]    w_state_nxt;

   logic [10:0]   w_strobes;
   logic          w_is_load;
   logic          w_is_store;
   logic [1:0]    w_size;       // 0=byte 1=half 2=word 3=dword
   logic          w_misaligned;
   logic          w_ok;         // exactly one strobe and naturally aligned
   logic [7:0]    w_wmask;
   logic          w_accept;

   logic          r_we;
   logic          r_load;
   logic          r_signed;
   logic          r_err;
   logic [1:0]    r_size;
   logic [2:0]    r_off;
   logic [AW-1:0] r_addr;
   logic [63:0]   r_wdata;
   logic [7:0]    r_wmask;
   logic [63:0]   r_rdata;

   logic [63:0]   w_lane;
   logic [63:0]   w_load_val;

   assign w_accept = req_valid && (r_state == ST_IDLE);

   // Decode the strobes into size, direction, legality and byte mask
   always_comb begin
      w_strobes  = {lb, lh, lw, ld, lbu, lhu, lwu, sb, sh, sw, sd};
      w_is_load  = lb | lh | lw | ld | lbu | lhu | lwu;
      w_is_store = sb | sh | sw | sd;
      if (ld || sd)
         w_size = 2'd3;
      else if (lw || lwu || sw)
         w_size = 2'd2;
      else if (lh || lhu || sh)
         w_size = 2'd1;
      else
         w_size = 2'd0;
      case (w_size)
         2'd0:    begin w_misaligned = 1'b0;              w_wmask = 8'h01 << addr[2:0]; end
         2'd1:    begin w_misaligned = addr[0];           w_wmask = 8'h03 << addr[2:0]; end
         2'd2:    begin w_misaligned = |addr[1:0];        w_wmask = 8'h0F << addr[2:0]; end
         default: begin w_misaligned = |addr[2:0];        w_wmask = 8'hFF;              end
      endcase
      w_ok = $onehot(w_strobes) && !w_misaligned;
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   // Next-state logic; illegal requests skip the memory phase entirely
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (req_valid) w_state_nxt = w_ok ? ST_REQ : ST_RSP;
         ST_REQ:  if (mem_ack)   w_state_nxt = ST_RSP;
         ST_RSP:  if (rsp_ready) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Outputs: bus fields are only driven while their phase is active
   always_comb begin
      req_ready = (r_state == ST_IDLE);
      mem_req   = (r_state == ST_REQ);
      rsp_valid = (r_state == ST_RSP);
      mem_we    = mem_req & r_we;
      mem_addr  = mem_req ? r_addr  : '0;
      mem_wdata = mem_req ? r_wdata : '0;
      mem_wmask = mem_req ? r_wmask : '0;
      rsp_rdata = rsp_valid ? r_rdata : '0;
      rsp_err   = rsp_valid & r_err;
   end

   // Extract the addressed lane from the read word and extend it
   always_comb begin
      w_lane = mem_rdata >> {r_off, 3'b000};
      case (r_size)
         2'd0:    w_load_val = r_signed ? {{56{w_lane[7]}},  w_lane[7:0]}  : {56'd0, w_lane[7:0]};
         2'd1:    w_load_val = r_signed ? {{48{w_lane[15]}}, w_lane[15:0]} : {48'd0, w_lane[15:0]};
         2'd2:    w_load_val = r_signed ? {{32{w_lane[31]}}, w_lane[31:0]} : {32'd0, w_lane[31:0]};
         default: w_load_val = w_lane;
      endcase
   end

   // Capture request fields on accept and load data on acknowledge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we     <= 1'b0;
         r_load   <= 1'b0;
         r_signed <= 1'b0;
         r_err    <= 1'b0;
         r_size   <= 2'd0;
         r_off    <= 3'd0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_wmask  <= '0;
         r_rdata  <= '0;
      end else if (w_accept) begin
         r_we     <= w_is_store;
         r_load   <= w_is_load;
         r_signed <= lb | lh | lw;
         r_err    <= !w_ok;
         r_size   <= w_size;
         r_off    <= addr[2:0];
         r_addr   <= {addr[AW-1:3], 3'b000};
         r_wdata  <= wdata << {addr[2:0], 3'b000};
         r_wmask  <= w_wmask;
         r_rdata  <= '0;
      end else if ((r_state == ST_REQ) && mem_ack) begin
         r_rdata  <= r_load ? w_load_val : 64'd0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_access.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_mem_access
// Description : Directed self-checking bench for lsu_mem_access.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_access;

   localparam int AW = 64;

   // Strobe vector order: {lb,lh,lw,ld,lbu,lhu,lwu,sb,sh,sw,sd}
   localparam logic [10:0] S_LB  = 11'b100_0000_0000;
   localparam logic [10:0] S_LW  = 11'b001_0000_0000;
   localparam logic [10:0] S_LD  = 11'b000_1000_0000;
   localparam logic [10:0] S_LBU = 11'b000_0100_0000;
   localparam logic [10:0] S_LHU = 11'b000_0010_0000;
   localparam logic [10:0] S_LWU = 11'b000_0001_0000;
   localparam logic [10:0] S_SB  = 11'b000_0000_1000;
   localparam logic [10:0] S_SH  = 11'b000_0000_0100;
   localparam logic [10:0] S_SW  = 11'b000_0000_0010;
   localparam logic [10:0] S_SD  = 11'b000_0000_0001;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [10:0]   strb = '0;
   logic [AW-1:0] addr = '0;
   logic [63:0]   wdata = '0;
   logic          mem_req, mem_we;
   logic [AW-1:0] mem_addr;
   logic [63:0]   mem_wdata;
   logic [7:0]    mem_wmask;
   logic          mem_ack = 1'b0;
   logic [63:0]   mem_rdata = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b1;
   logic [63:0]   rsp_rdata;
   logic          rsp_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   lsu_mem_access #(.AW(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .lb(strb[10]), .lh(strb[9]), .lw(strb[8]), .ld(strb[7]),
      .lbu(strb[6]), .lhu(strb[5]), .lwu(strb[4]),
      .sb(strb[3]), .sh(strb[2]), .sw(strb[1]), .sd(strb[0]),
      .addr(addr), .wdata(wdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called 1 time unit after a rising edge with the DUT idle.
   task automatic access(input string tag, input logic [10:0] s, input logic [63:0] a,
                         input logic [63:0] wd, input logic [63:0] rd,
                         input int ack_dly, input int stall,
                         input logic exp_err, input logic exp_we, input logic [7:0] exp_mask,
                         input logic [63:0] exp_addr, input logic [63:0] exp_wdata,
                         input logic [63:0] exp_rdata);
      strb = s; addr = a; wdata = wd; req_valid = 1'b1;
      #1;
      check({tag, "/req_ready"}, 64'(req_ready), 64'd1);
      tick();
      strb = '0; addr = '0; wdata = '0; req_valid = 1'b0;
      if (!exp_err) begin
         for (int i = 0; i <= ack_dly; i++) begin
            if (i == ack_dly) begin
               mem_ack = 1'b1; mem_rdata = rd;
            end
            check({tag, "/mem_req"},   64'(mem_req),   64'd1);
            check({tag, "/mem_we"},    64'(mem_we),    64'(exp_we));
            check({tag, "/mem_addr"},  mem_addr,       exp_addr);
            check({tag, "/mem_wmask"}, 64'(mem_wmask), 64'(exp_mask));
            check({tag, "/mem_wdata"}, mem_wdata,      exp_wdata);
            check({tag, "/rdy_busy"},  64'(req_ready), 64'd0);
            tick();
         end
         mem_ack = 1'b0; mem_rdata = '0;
      end
      check({tag, "/mem_req_off"}, 64'(mem_req), 64'd0);
      rsp_ready = 1'b0;
      for (int i = 0; i <= stall; i++) begin
         if (i == stall) rsp_ready = 1'b1;
         check({tag, "/rsp_valid"}, 64'(rsp_valid), 64'd1);
         check({tag, "/rsp_err"},   64'(rsp_err),   64'(exp_err));
         check({tag, "/rsp_rdata"}, rsp_rdata,      exp_rdata);
         check({tag, "/rdy_rsp"},   64'(req_ready), 64'd0);
         tick();
      end
      check({tag, "/rsp_done"}, 64'(rsp_valid), 64'd0);
      check({tag, "/rdy_idle"}, 64'(req_ready), 64'd1);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst/req_ready", 64'(req_ready), 64'd1);
      check("rst/mem_req",   64'(mem_req),   64'd0);
      check("rst/mem_wmask", 64'(mem_wmask), 64'd0);
      check("rst/mem_addr",  mem_addr,       64'd0);
      check("rst/rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst/rsp_rdata", rsp_rdata,      64'd0);
      rst_n = 1'b1;
      tick();

      // Stray acknowledge while idle must not start anything
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      check("stray/mem_req",   64'(mem_req),   64'd0);
      check("stray/rsp_valid", 64'(rsp_valid), 64'd0);

      access("lw",  S_LW,  64'hFFFF_0000_0000_1004, 64'd0, 64'h8000_0001_8765_4321, 0, 0,
             1'b0, 1'b0, 8'hF0, 64'hFFFF_0000_0000_1000, 64'd0, 64'hFFFF_FFFF_8000_0001);
      access("lbu", S_LBU, 64'h0000_0000_0000_0007, 64'd0, 64'hAB00_0000_0000_0000, 0, 0,
             1'b0, 1'b0, 8'h80, 64'h0, 64'd0, 64'h0000_0000_0000_00AB);
      access("lb",  S_LB,  64'h0000_0000_0000_0007, 64'd0, 64'hAB00_0000_0000_0000, 0, 0,
             1'b0, 1'b0, 8'h80, 64'h0, 64'd0, 64'hFFFF_FFFF_FFFF_FFAB);
      access("sh",  S_SH,  64'h0000_0000_0000_0002, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0,
             1'b0, 1'b1, 8'h0C, 64'h0, 64'h5678_9ABC_DEF0_0000, 64'd0);
      access("sd_mis", S_SD, 64'h0000_0000_0000_0004, 64'h55, 64'd0, 0, 0,
             1'b1, 1'b0, 8'h00, 64'h0, 64'd0, 64'd0);
      access("lw_sw",  S_LW | S_SW, 64'h0000_0000_0000_0008, 64'h55, 64'd0, 0, 0,
             1'b1, 1'b0, 8'h00, 64'h0, 64'd0, 64'd0);
      access("none",   11'd0, 64'h0000_0000_0000_0008, 64'h55, 64'd0, 0, 0,
             1'b1, 1'b0, 8'h00, 64'h0, 64'd0, 64'd0);
      access("lhu_slow", S_LHU, 64'h0000_0000_0000_00A6, 64'd0, 64'h9876_0000_0000_0000, 5, 3,
             1'b0, 1'b0, 8'hC0, 64'h0000_0000_0000_00A0, 64'd0, 64'h0000_0000_0000_9876);
      access("ld",  S_LD,  64'h0000_0000_0000_0018, 64'd0, 64'h0123_4567_89AB_CDEF, 1, 0,
             1'b0, 1'b0, 8'hFF, 64'h0000_0000_0000_0018, 64'd0, 64'h0123_4567_89AB_CDEF);
      access("lwu", S_LWU, 64'h0000_0000_0000_0004, 64'd0, 64'h8000_0001_8765_4321, 0, 1,
             1'b0, 1'b0, 8'hF0, 64'h0, 64'd0, 64'h0000_0000_8000_0001);
      access("sb",  S_SB,  64'h0000_0000_0000_0005, 64'h0000_0000_0000_00EF, 64'd0, 2, 0,
             1'b0, 1'b1, 8'h20, 64'h0, 64'h0000_EF00_0000_0000, 64'd0);

      // Reset while waiting for an acknowledge abandons the access
      strb = S_LD; addr = 64'h40; req_valid = 1'b1;
      tick();
      strb = '0; addr = '0; req_valid = 1'b0;
      check("rstreq/mem_req_on", 64'(mem_req), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rstreq/mem_req",   64'(mem_req),   64'd0);
      check("rstreq/mem_addr",  mem_addr,       64'd0);
      check("rstreq/mem_wmask", 64'(mem_wmask), 64'd0);
      check("rstreq/req_ready", 64'(req_ready), 64'd1);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("rstreq/no_rsp",    64'(rsp_valid), 64'd0);
         check("rstreq/rdy_after", 64'(req_ready), 64'd1);
         tick();
      end
      access("sw_after", S_SW, 64'h0000_0000_0000_0010, 64'h0000_0000_CAFE_F00D, 64'd0, 0, 0,
             1'b0, 1'b1, 8'h0F, 64'h0000_0000_0000_0010, 64'h0000_0000_CAFE_F00D, 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
